// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle control path:
// supported opcodes, sequencer states and ALU operation codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERROR
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } alu_op_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_BEQ) || (op == OP_RTYPE) || (op == OP_STORE) ||
           (op == OP_LOAD) || (op == OP_ITYPE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for the current request; expired flags the
// cycle in which the count has reached the timeout limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic count_en,
  output logic expired
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (count_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = (r_cnt == TW'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core: steps FETCH/DECODE/EXEC/MEM/WB,
// drives datapath controls and the shared memory request/ready handshake.
//
//  state     | meaning
//  ----------+----------------------------------------------------------
//  ST_IDLE   | one cycle after reset, outputs idle
//  ST_FETCH  | instruction read at PC, IR loads on mem_ready
//  ST_DECODE | latch opcode, reject unsupported ones (skip to next PC)
//  ST_EXEC   | ALU operation; BEQ/BNE resolves and retires here
//  ST_MEM    | data access at ALU address; STORE retires on mem_ready
//  ST_WB     | register write-back and PC+4
//  ST_ERROR  | memory timeout, halted until reset
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TW          = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       pc_src,
  output logic       reg_wr,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal_instr,
  output logic       halted
);

  ctrl_state_t r_state, w_next;
  logic [6:0]  r_op_q;
  alu_op_t     w_alu_op;
  logic        w_expired;
  logic        w_unused;

  assign w_unused = |funct3[2:1];

  // Counter is held at zero whenever no request is pending, so it restarts
  // on every FETCH/MEM entry and after each completed access.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TW          (TW)
  ) u_wait_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (~mem_req | mem_ready),
    .count_en (mem_req & ~mem_ready),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_op_q <= '0;
    end else if (r_state == ST_DECODE) begin
      r_op_q <= opcode;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      w_next = ST_DECODE;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_DECODE: w_next = is_legal_op(opcode) ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        if (r_op_q == OP_BEQ)                              w_next = ST_FETCH;
        else if ((r_op_q == OP_LOAD) || (r_op_q == OP_STORE)) w_next = ST_MEM;
        else                                               w_next = ST_WB;
      end
      ST_MEM: begin
        if (mem_ready)      w_next = (r_op_q == OP_LOAD) ? ST_WB : ST_FETCH;
        else if (w_expired) w_next = ST_ERROR;
      end
      ST_WB:     w_next = ST_FETCH;
      ST_ERROR:  w_next = ST_ERROR;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_wr         = 1'b0;
    pc_wr         = 1'b0;
    pc_src        = 1'b0;
    reg_wr        = 1'b0;
    alu_src       = 1'b0;
    w_alu_op      = ALU_ADD;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    halted        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_wr   = mem_ready;
      end
      ST_DECODE: begin
        illegal_instr = ~is_legal_op(opcode);
        pc_wr         = ~is_legal_op(opcode);
      end
      ST_EXEC, ST_WB: begin
        // WB keeps the EXEC ALU setup so the result stays stable for write-back.
        case (r_op_q)
          OP_BEQ:   w_alu_op = ALU_SUB;
          OP_RTYPE: w_alu_op = ALU_RFUNCT;
          OP_ITYPE: begin
            w_alu_op = ALU_IFUNCT;
            alu_src  = 1'b1;
          end
          default:  alu_src = 1'b1;
        endcase
        if (r_state == ST_WB) begin
          reg_wr     = 1'b1;
          mem_to_reg = (r_op_q == OP_LOAD);
          pc_wr      = 1'b1;
          retire     = 1'b1;
        end else if (r_op_q == OP_BEQ) begin
          pc_wr  = 1'b1;
          pc_src = zero ^ funct3[0];
          retire = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        alu_src  = 1'b1;
        mem_we   = (r_op_q == OP_STORE);
        if (mem_ready && (r_op_q == OP_STORE)) begin
          pc_wr  = 1'b1;
          retire = 1'b1;
        end
      end
      ST_ERROR:  halted = 1'b1;
      default: ;
    endcase
  end

  assign alu_op = w_alu_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: a memory responder
// serves a generated program, a monitor checks retire/illegal/halt events.
module tb_multicycle_control;

  localparam int MT = 15;
  localparam int K_RET = 0, K_ILL = 1, K_HALT = 2;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  logic clk = 1'b0, n_rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, addr_sel, ir_wr, pc_wr, pc_src, reg_wr, alu_src;
  logic [1:0] alu_op;
  logic mem_to_reg, retire, illegal_instr, halted;

  multicycle_control #(.MEM_TIMEOUT(MT), .TW(4)) dut (
    .clk(clk), .n_rst(n_rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
    .reg_wr(reg_wr), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .retire(retire), .illegal_instr(illegal_instr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic z; int fw; int dw;
  } instr_t;
  typedef struct {
    int kind; int t; logic psrc; logic rwr; logic m2r; logic [1:0] aop; logic asrc;
  } exp_t;

  instr_t prog[$];
  exp_t   sb[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit run = 1'b0, halt_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [6:0] op);
    return op == OPC_BEQ || op == OPC_RTYPE || op == OPC_STORE ||
           op == OPC_LOAD || op == OPC_ITYPE;
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3,
                                input logic z, input int fw, input int dw);
    instr_t i;
    i.op = op; i.f3 = f3; i.z = z; i.fw = fw; i.dw = dw;
    return i;
  endfunction

  function automatic int rnd_wait();
    return ($urandom_range(0, 7) == 0) ? MT : int'($urandom_range(0, 3));
  endfunction

  function automatic instr_t rnd_instr();
    instr_t i;
    int c;
    c = int'($urandom_range(0, 5));
    case (c)
      0: i.op = OPC_BEQ;
      1: i.op = OPC_RTYPE;
      2: i.op = OPC_STORE;
      3: i.op = OPC_LOAD;
      4: i.op = OPC_ITYPE;
      default: begin
        i.op = 7'($urandom_range(0, 127));
        while (legal(i.op)) i.op = 7'($urandom_range(0, 127));
      end
    endcase
    i.f3 = 3'($urandom_range(0, 7));
    i.z  = 1'($urandom_range(0, 1));
    i.fw = rnd_wait();
    i.dw = rnd_wait();
    return i;
  endfunction

  // Reference timeline: cycle 0 is the IDLE cycle after reset release; each
  // instruction's event time follows from its class and memory waits.
  task automatic build_model();
    int t0, td, tm;
    instr_t i;
    exp_t e;
    t0 = 1;
    sb.delete();
    for (int k = 0; k < prog.size(); k++) begin
      i = prog[k];
      e = '{K_RET, 0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
      if (i.fw > MT) begin
        e.kind = K_HALT; e.t = t0 + MT + 1; sb.push_back(e);
        break;
      end
      td = t0 + i.fw + 1;
      if (!legal(i.op)) begin
        e.kind = K_ILL; e.t = td; t0 = td + 1;
      end else if (i.op == OPC_BEQ) begin
        e.t = td + 1; e.psrc = i.z ^ i.f3[0]; e.aop = 2'b01; t0 = td + 2;
      end else if (i.op == OPC_RTYPE || i.op == OPC_ITYPE) begin
        e.t = td + 2; e.rwr = 1'b1; t0 = td + 3;
        e.aop  = (i.op == OPC_RTYPE) ? 2'b10 : 2'b11;
        e.asrc = (i.op == OPC_ITYPE);
      end else begin
        tm = td + 2;
        if (i.dw > MT) begin
          e.kind = K_HALT; e.t = tm + MT + 1; sb.push_back(e);
          break;
        end
        e.asrc = 1'b1;
        if (i.op == OPC_STORE) e.t = tm + i.dw;
        else begin e.t = tm + i.dw + 1; e.rwr = 1'b1; e.m2r = 1'b1; end
        t0 = e.t + 1;
      end
      sb.push_back(e);
    end
  endtask

  // Memory responder: serves fetches and data accesses with the programmed waits.
  initial begin : responder
    int idx, waited, tgt;
    bit data_ph;
    instr_t cur;
    idx = -1; waited = 0; data_ph = 1'b0;
    cur = mk(7'h00, 3'h0, 1'b0, 0, 0);
    forever begin
      @(negedge clk);
      if (!run) begin
        mem_ready = 1'b0; idx = -1; waited = 0; data_ph = 1'b0;
      end else if (mem_req) begin
        if (waited == 0 && !data_ph) begin
          idx++;
          if (idx < prog.size()) begin
            cur = prog[idx];
            opcode = cur.op; funct3 = cur.f3; zero = cur.z;
          end
        end
        chk("addr_sel", addr_sel, data_ph);
        chk("mem_we", mem_we, data_ph && (cur.op == OPC_STORE));
        tgt = data_ph ? cur.dw : cur.fw;
        if (waited == tgt) begin
          mem_ready = 1'b1; waited = 0;
          data_ph = !data_ph && (cur.op == OPC_LOAD || cur.op == OPC_STORE);
        end else begin
          mem_ready = 1'b0; waited++;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin : monitor
    exp_t e;
    int kind;
    forever begin
      @(negedge clk);
      #1;
      if (run) begin
        cyc++;
        if (retire || illegal_instr || (halted && !halt_seen)) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {retire, illegal_instr, halted}, 0);
          end else begin
            e = sb.pop_front();
            kind = retire ? K_RET : (illegal_instr ? K_ILL : K_HALT);
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.t);
            if (e.kind == K_RET) begin
              chk("ret_pc_wr", pc_wr, 1);
              chk("ret_pc_src", pc_src, e.psrc);
              chk("ret_reg_wr", reg_wr, e.rwr);
              chk("ret_mem_to_reg", mem_to_reg, e.m2r);
              chk("ret_alu_op", alu_op, e.aop);
              chk("ret_alu_src", alu_src, e.asrc);
            end else if (e.kind == K_ILL) begin
              chk("ill_pc", {pc_wr, pc_src}, 2'b10);
              chk("ill_no_retire", {retire, reg_wr}, 0);
            end else begin
              chk("halt_quiet", {mem_req, pc_wr, retire}, 0);
            end
          end
        end
        if (halted) halt_seen = 1'b1;
      end
    end
  end

  initial begin : stim
    bit done;
    for (int ep = 0; ep < 2; ep++) begin
      prog.delete();
      if (ep == 0) begin
        prog.push_back(mk(OPC_RTYPE, 3'h0, 1'b0, 0, 0));
        prog.push_back(mk(OPC_BEQ,   3'h0, 1'b1, 0, 0));
        prog.push_back(mk(OPC_BEQ,   3'h1, 1'b1, 0, 0));
        prog.push_back(mk(OPC_LOAD,  3'h2, 1'b0, 0, 3));
        prog.push_back(mk(OPC_STORE, 3'h2, 1'b0, 0, 0));
        prog.push_back(mk(7'h7F,     3'h0, 1'b0, 0, 0));
        prog.push_back(mk(OPC_ITYPE, 3'h0, 1'b0, MT, 0));
        prog.push_back(mk(OPC_STORE, 3'h2, 1'b0, 1, MT));
      end
      for (int k = 0; k < 25; k++) prog.push_back(rnd_instr());
      if (ep == 0) prog.push_back(mk(OPC_RTYPE, 3'h0, 1'b0, MT + 1, 0));
      else         prog.push_back(mk(OPC_LOAD,  3'h2, 1'b0, 0, MT + 1));
      build_model();

      @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("reset_outputs", {mem_req, mem_we, addr_sel, ir_wr, pc_wr, pc_src, reg_wr,
                            alu_src, alu_op, mem_to_reg, retire, illegal_instr, halted}, 0);
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1; cyc = -1; halt_seen = 1'b0; run = 1'b1;

      done = 1'b0;
      for (int k = 0; k < 4000 && !done; k++) begin
        @(negedge clk);
        #2;
        done = halt_seen && (sb.size() == 0);
      end
      chk("episode_done", {halt_seen, sb.size() == 0}, 2'b11);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #2;
        chk("halted_sticky", {halted, mem_req, retire, pc_wr}, 4'b1000);
      end
      run = 1'b0;
    end

    @(negedge clk);
    #2 n_rst = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      done = mem_req;
    end
    chk("fetch_req_seen", mem_req, 1);
    #2 n_rst = 1'b0;
    #1;
    chk("async_abort", {mem_req, ir_wr, halted}, 0);
    #5 n_rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
